// File: rtl/iir_pkg.sv
// Shared types and helpers for the direct-form-I IIR filter.
package iir_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StMac,
    StOut
  } iir_state_e;

  // Widest intermediate the saturation helper can classify.
  localparam int unsigned SatWidth = 128;

  // Accumulator must hold the sum of all full-width products without wrapping.
  function automatic int unsigned acc_width(input int unsigned data_width,
                                            input int unsigned num_terms);
    return 2 * data_width + $clog2(num_terms) + 1;
  endfunction

  // Classify a wide signed value against the signed data_width range:
  // bit 1 = above maximum, bit 0 = below minimum.
  function automatic logic [1:0] saturate(input logic signed [SatWidth-1:0] value,
                                          input int unsigned data_width);
    logic signed [SatWidth-1:0] max_v;
    logic signed [SatWidth-1:0] min_v;
    max_v = (128'sd1 <<< (data_width - 1)) - 128'sd1;
    min_v = -max_v - 128'sd1;
    return {(value > max_v), (value < min_v)};
  endfunction

endpackage

// File: rtl/iir_mac_slice.sv
// One compute cycle's worth of signed multiplies summed at accumulator width.
module iir_mac_slice
  import iir_pkg::*;
#(
  parameter int unsigned Lanes     = 8,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AccWidth  = 69
) (
  input  logic signed [DataWidth-1:0] coef        [Lanes],
  input  logic signed [DataWidth-1:0] sample      [Lanes],
  input  logic        [Lanes-1:0]     lane_valid,
  input  logic        [Lanes-1:0]     lane_negate,
  output logic signed [AccWidth-1:0]  sum
);

  localparam int unsigned LaneIdxW = (Lanes > 1) ? $clog2(Lanes) : 1;

  logic signed [2*DataWidth-1:0] prod [Lanes];

  // Full-width products, masked and signed into a single sum (adder tree after synthesis).
  always_comb begin
    prod = '{default: '0};
    sum  = '0;
    for (int unsigned l = 0; l < Lanes; l++) begin
      prod[LaneIdxW'(l)] = coef[LaneIdxW'(l)] * sample[LaneIdxW'(l)];
      if (lane_valid[LaneIdxW'(l)]) begin
        if (lane_negate[LaneIdxW'(l)]) begin
          sum = sum - AccWidth'(prod[LaneIdxW'(l)]);
        end else begin
          sum = sum + AccWidth'(prod[LaneIdxW'(l)]);
        end
      end
    end
  end

endmodule

// File: rtl/iir_filter.sv
// Multi-cycle direct-form-I IIR filter with optional decimation.
module iir_filter
  import iir_pkg::*;
#(
  parameter int unsigned TAP_COUNT         = 8,
  parameter int unsigned FB_TAP_COUNT      = 3,
  parameter int unsigned DECIMATION_FACTOR = 1,
  parameter int unsigned MULT_PER_CYCLE    = 8,
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned FRAC_BITS         = 0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic signed [DATA_WIDTH-1:0] newData,
  input  logic                         newDataAvailable,
  input  logic signed [DATA_WIDTH-1:0] FEEDFORWARD_TAPS [TAP_COUNT],
  input  logic signed [DATA_WIDTH-1:0] FEEDBACK_TAPS    [FB_TAP_COUNT],
  output logic signed [DATA_WIDTH-1:0] filteredData,
  output logic                         done
);

  localparam int unsigned NumTerms  = TAP_COUNT + FB_TAP_COUNT;
  localparam int unsigned NumPasses = (NumTerms + MULT_PER_CYCLE - 1) / MULT_PER_CYCLE;
  localparam int unsigned AccW      = acc_width(DATA_WIDTH, NumTerms);
  localparam int unsigned CycW      = $clog2(NumPasses + 1);
  localparam int unsigned DecW      = $clog2(DECIMATION_FACTOR + 1);
  localparam int unsigned TapIdxW   = (TAP_COUNT > 1) ? $clog2(TAP_COUNT) : 1;
  localparam int unsigned FbIdxW    = (FB_TAP_COUNT > 1) ? $clog2(FB_TAP_COUNT) : 1;
  localparam int unsigned LaneIdxW  = (MULT_PER_CYCLE > 1) ? $clog2(MULT_PER_CYCLE) : 1;

  iir_state_e                  state_q, state_d;
  logic signed [AccW-1:0]      acc_q, acc_d;
  logic        [CycW-1:0]      cyc_q, cyc_d;
  logic        [DecW-1:0]      dec_q, dec_d;
  logic signed [DATA_WIDTH-1:0] x_q [TAP_COUNT];
  logic signed [DATA_WIDTH-1:0] x_d [TAP_COUNT];
  logic signed [DATA_WIDTH-1:0] y_q [FB_TAP_COUNT];
  logic signed [DATA_WIDTH-1:0] y_d [FB_TAP_COUNT];
  logic signed [DATA_WIDTH-1:0] filt_q, filt_d;
  logic                        done_q, done_d;

  logic signed [DATA_WIDTH-1:0] op_coef   [MULT_PER_CYCLE];
  logic signed [DATA_WIDTH-1:0] op_sample [MULT_PER_CYCLE];
  logic        [MULT_PER_CYCLE-1:0] lane_valid;
  logic        [MULT_PER_CYCLE-1:0] lane_negate;
  logic signed [AccW-1:0]      slice_sum;

  logic signed [AccW-1:0]      acc_shifted;
  logic signed [SatWidth-1:0]  sat_in;
  logic        [1:0]           sat_flags;
  logic signed [DATA_WIDTH-1:0] y_new;

  // Pick this cycle's operand window from the concatenated term list (b*x then a*y).
  always_comb begin
    op_coef     = '{default: '0};
    op_sample   = '{default: '0};
    lane_valid  = '0;
    lane_negate = '0;
    for (int unsigned l = 0; l < MULT_PER_CYCLE; l++) begin
      int unsigned term;
      term = 32'(cyc_q) * MULT_PER_CYCLE + l;
      if (term < TAP_COUNT) begin
        op_coef[LaneIdxW'(l)]    = FEEDFORWARD_TAPS[TapIdxW'(term)];
        op_sample[LaneIdxW'(l)]  = x_q[TapIdxW'(term)];
        lane_valid[LaneIdxW'(l)] = 1'b1;
      end else if (term < NumTerms) begin
        op_coef[LaneIdxW'(l)]     = FEEDBACK_TAPS[FbIdxW'(term - TAP_COUNT)];
        op_sample[LaneIdxW'(l)]   = y_q[FbIdxW'(term - TAP_COUNT)];
        lane_valid[LaneIdxW'(l)]  = 1'b1;
        lane_negate[LaneIdxW'(l)] = 1'b1;
      end
    end
  end

  iir_mac_slice #(
    .Lanes     (MULT_PER_CYCLE),
    .DataWidth (DATA_WIDTH),
    .AccWidth  (AccW)
  ) u_mac_slice (
    .coef        (op_coef),
    .sample      (op_sample),
    .lane_valid  (lane_valid),
    .lane_negate (lane_negate),
    .sum         (slice_sum)
  );

  // Scale the accumulator and clamp it into the output range.
  always_comb begin
    acc_shifted = acc_q >>> FRAC_BITS;
    sat_in      = SatWidth'(acc_shifted);
    sat_flags   = saturate(sat_in, DATA_WIDTH);
    y_new       = acc_shifted[DATA_WIDTH-1:0];
    if (sat_flags[1]) begin
      y_new = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else if (sat_flags[0]) begin
      y_new = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end
  end

  // Next-state logic: accept/decimate in idle, accumulate in MAC, publish in OUT.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cyc_d   = cyc_q;
    dec_d   = dec_q;
    x_d     = x_q;
    y_d     = y_q;
    filt_d  = filt_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (newDataAvailable) begin
          x_d[0] = newData;
          for (int unsigned k = 1; k < TAP_COUNT; k++) begin
            x_d[TapIdxW'(k)] = x_q[TapIdxW'(k - 1)];
          end
          if (dec_q == DecW'(DECIMATION_FACTOR - 1)) begin
            dec_d   = '0;
            acc_d   = '0;
            cyc_d   = '0;
            state_d = StMac;
          end else begin
            dec_d = dec_q + DecW'(1);
          end
        end
      end
      StMac: begin
        acc_d = acc_q + slice_sum;
        cyc_d = cyc_q + CycW'(1);
        if (cyc_q == CycW'(NumPasses - 1)) begin
          state_d = StOut;
        end
      end
      StOut: begin
        filt_d = y_new;
        y_d[0] = y_new;
        for (int unsigned j = 1; j < FB_TAP_COUNT; j++) begin
          y_d[FbIdxW'(j)] = y_q[FbIdxW'(j - 1)];
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register; reset aborts any computation in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cyc_q   <= '0;
      dec_q   <= '0;
      x_q     <= '{default: '0};
      y_q     <= '{default: '0};
      filt_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cyc_q   <= cyc_d;
      dec_q   <= dec_d;
      x_q     <= x_d;
      y_q     <= y_d;
      filt_q  <= filt_d;
      done_q  <= done_d;
    end
  end

  assign filteredData = filt_q;
  assign done         = done_q;

endmodule

// File: tb/tb_iir_filter.sv
// Directed bench for iir_filter: default instance plus a decimate-by-2 instance.
module tb_iir_filter;

  logic               clock = 1'b0;
  logic               reset;
  logic               nda;
  logic signed [31:0] new_data;
  logic signed [31:0] ff_taps [8];
  logic signed [31:0] fb_taps [3];
  logic signed [31:0] filt, filt_d2;
  logic               done, done_d2;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  iir_filter dut (
    .clock            (clock),
    .reset            (reset),
    .newData          (new_data),
    .newDataAvailable (nda),
    .FEEDFORWARD_TAPS (ff_taps),
    .FEEDBACK_TAPS    (fb_taps),
    .filteredData     (filt),
    .done             (done)
  );

  iir_filter #(.DECIMATION_FACTOR(2)) dut_dec (
    .clock            (clock),
    .reset            (reset),
    .newData          (new_data),
    .newDataAvailable (nda),
    .FEEDFORWARD_TAPS (ff_taps),
    .FEEDBACK_TAPS    (fb_taps),
    .filteredData     (filt_d2),
    .done             (done_d2)
  );

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1;
    nda   = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // Strobe one sample, then watch up to 8 cycles for done; at = cycles until done seen.
  task automatic send_sample(input logic signed [31:0] x, input bit sel, output bit seen,
                             output logic signed [31:0] y, output int at);
    @(negedge clock);
    new_data = x;
    nda      = 1'b1;
    @(negedge clock);
    nda  = 1'b0;
    seen = 1'b0;
    y    = '0;
    at   = -1;
    for (int i = 0; i < 8; i++) begin
      if (!seen && (sel ? done_d2 : done)) begin
        seen = 1'b1;
        y    = sel ? filt_d2 : filt;
        at   = i;
      end
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    bit seen;
    logic signed [31:0] y;
    int at;
    int bad;
    // Populate histories with nonzero values first.
    apply_reset();
    ff_taps = '{default: 32'sd1};
    fb_taps = '{default: 32'sd1};
    send_sample(32'sd2, 1'b0, seen, y, at);
    send_sample(32'sd3, 1'b0, seen, y, at);
    @(negedge clock);
    reset = 1'b1;
    bad   = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      tests_run++;
      if (filt !== 32'sd0 || done !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_hold[%0d]: filteredData=%0d done=%0b, required 0/0", i, filt, done);
      end
      nda      = 1'($urandom_range(0, 1));
      new_data = 32'($urandom);
    end
    nda   = 1'b0;
    reset = 1'b0;
    // Cleared histories: y = 5 with all feedback terms zero.
    send_sample(32'sd5, 1'b0, seen, y, at);
    tests_run++;
    if (!seen || y !== 32'sd5) begin
      tests_failed++;
      $display("FAIL reset_first_out: seen=%0b got %0d, required 5", seen, y);
    end
  endtask

  task automatic test_impulse();
    bit seen;
    logic signed [31:0] y;
    int at;
    logic signed [31:0] exp_y;
    apply_reset();
    ff_taps = '{32'sd1, 32'sd2, 32'sd3, 32'sd4, 32'sd5, 32'sd6, 32'sd7, 32'sd8};
    fb_taps = '{default: 32'sd0};
    for (int n = 0; n < 9; n++) begin
      exp_y = (n < 8) ? 32'(n + 1) : 32'sd0;
      send_sample((n == 0) ? 32'sd1 : 32'sd0, 1'b0, seen, y, at);
      tests_run++;
      if (!seen || y !== exp_y) begin
        tests_failed++;
        $display("FAIL impulse[%0d]: seen=%0b got %0d, required %0d", n, seen, y, exp_y);
      end
    end
  endtask

  task automatic test_feedback();
    bit seen;
    logic signed [31:0] y;
    int at;
    logic signed [31:0] exp_y [4];
    exp_y = '{32'sd1, -32'sd1, 32'sd1, -32'sd1};
    apply_reset();
    ff_taps = '{32'sd1, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0};
    fb_taps = '{32'sd1, 32'sd0, 32'sd0};
    for (int n = 0; n < 4; n++) begin
      send_sample((n == 0) ? 32'sd1 : 32'sd0, 1'b0, seen, y, at);
      tests_run++;
      if (!seen || y !== exp_y[n]) begin
        tests_failed++;
        $display("FAIL feedback[%0d]: seen=%0b got %0d, required %0d", n, seen, y, exp_y[n]);
      end
    end
  endtask

  task automatic test_latency();
    bit exp_done;
    apply_reset();
    ff_taps = '{32'sd1, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0};
    fb_taps = '{default: 32'sd0};
    // Sample i is driven at negedge i; accepted samples 0,4,8 emerge 4 negedges later.
    for (int i = 0; i < 17; i++) begin
      @(negedge clock);
      exp_done = (i >= 4) && (i % 4 == 0);
      tests_run++;
      if (done !== exp_done) begin
        tests_failed++;
        $display("FAIL latency_done[%0d]: done=%0b, required %0b", i, done, exp_done);
      end else if (exp_done && filt !== 32'(i - 4)) begin
        tests_failed++;
        $display("FAIL latency_data[%0d]: got %0d, required %0d", i, filt, i - 4);
      end
      new_data = 32'(i);
      nda      = 1'b1;
    end
    nda = 1'b0;
  endtask

  task automatic test_decimation();
    bit seen;
    logic signed [31:0] y;
    int at;
    apply_reset();
    ff_taps = '{32'sd1, 32'sd1, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0};
    fb_taps = '{default: 32'sd0};
    for (int n = 1; n <= 4; n++) begin
      send_sample(32'(n), 1'b1, seen, y, at);
      tests_run++;
      if (n % 2 == 1) begin
        if (seen) begin
          tests_failed++;
          $display("FAIL decim_skip[%0d]: done seen, required none", n);
        end
      end else if (!seen || y !== ((n == 2) ? 32'sd3 : 32'sd7)) begin
        tests_failed++;
        $display("FAIL decim_out[%0d]: seen=%0b got %0d, required %0d", n, seen, y,
                 (n == 2) ? 3 : 7);
      end
    end
  endtask

  task automatic test_saturation();
    bit seen;
    logic signed [31:0] y;
    int at;
    ff_taps = '{default: 32'h7FFF_FFFF};
    fb_taps = '{default: 32'sd0};
    apply_reset();
    send_sample(32'h7FFF_FFFF, 1'b0, seen, y, at);
    tests_run++;
    if (!seen || y !== 32'h7FFF_FFFF) begin
      tests_failed++;
      $display("FAIL sat_pos: seen=%0b got %h, required 7fffffff", seen, y);
    end
    apply_reset();
    send_sample(32'h8000_0001, 1'b0, seen, y, at);
    tests_run++;
    if (!seen || y !== 32'h8000_0000) begin
      tests_failed++;
      $display("FAIL sat_neg: seen=%0b got %h, required 80000000", seen, y);
    end
  endtask

  task automatic test_abort();
    bit seen;
    logic signed [31:0] y;
    int at;
    int done_cnt;
    apply_reset();
    ff_taps = '{32'sd1, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0};
    fb_taps = '{default: 32'sd0};
    send_sample(32'sd3, 1'b0, seen, y, at);
    tests_run++;
    if (!seen || y !== 32'sd3 || at != 3) begin
      tests_failed++;
      $display("FAIL abort_pre: seen=%0b got %0d at %0d, required 3 at 3", seen, y, at);
    end
    @(negedge clock);
    new_data = 32'sd9;
    nda      = 1'b1;
    @(negedge clock);
    nda   = 1'b0;
    reset = 1'b1;
    done_cnt = 0;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (done) done_cnt++;
      @(negedge clock);
    end
    tests_run++;
    if (done_cnt != 0 || filt !== 32'sd0) begin
      tests_failed++;
      $display("FAIL abort: done pulses=%0d filteredData=%0d, required 0/0", done_cnt, filt);
    end
  endtask

  initial begin
    reset    = 1'b1;
    nda      = 1'b0;
    new_data = '0;
    ff_taps  = '{default: 32'sd0};
    fb_taps  = '{default: 32'sd0};
    @(negedge clock);
    tests_run++;
    if (filt !== 32'sd0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: filteredData=%0d done=%0b, required 0/0", filt, done);
    end
    reset = 1'b0;
    test_reset();
    test_impulse();
    test_feedback();
    test_latency();
    test_decimation();
    test_saturation();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
